// File: rtl/axi_fill_master_if.sv
// AXI4-Lite write-channel bundle between the fill master and its slave.
interface axi_fill_master_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );
endinterface

// File: rtl/axi_fill_master.sv
// Fills a word range with a constant via single-outstanding AXI4-Lite writes; 2 cycles/word
// with ready slave. Stalls on AWREADY/WREADY/BVALID; start is only sampled while idle.
module axi_fill_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 19,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int COUNT_WIDTH        = 17
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [COUNT_WIDTH-1:0]        word_count,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] fill_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [COUNT_WIDTH-1:0]        words_done,
    axi_fill_master_if.master             m_axi
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                    state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata;
    logic [COUNT_WIDTH-1:0]        count;
    logic                          awvalid;
    logic                          wvalid;
    logic                          bready;
    logic                          aw_ok;
    logic                          w_ok;

    assign m_axi.M_AXI_AWADDR  = awaddr;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid;
    assign m_axi.M_AXI_WDATA   = wdata;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WVALID  = wvalid;
    assign m_axi.M_AXI_BREADY  = bready;

    // A channel is finished once its valid is low or is being accepted this cycle.
    assign aw_ok = !awvalid || m_axi.M_AXI_AWREADY;
    assign w_ok  = !wvalid  || m_axi.M_AXI_WREADY;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= S_IDLE;
            awaddr     <= '0;
            wdata      <= '0;
            count      <= '0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        awaddr     <= base_addr & ~C_M_AXI_ADDR_WIDTH'(3);
                        wdata      <= fill_data;
                        count      <= word_count;
                        error      <= 1'b0;
                        words_done <= '0;
                        busy       <= 1'b1;
                        if (word_count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_WRITE;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (awvalid && m_axi.M_AXI_AWREADY) awvalid <= 1'b0;
                    if (wvalid && m_axi.M_AXI_WREADY)   wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        state  <= S_RESP;
                        bready <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (m_axi.M_AXI_BVALID && bready) begin
                        bready     <= 1'b0;
                        words_done <= words_done + COUNT_WIDTH'(1);
                        if (m_axi.M_AXI_BRESP != 2'b00) begin
                            error <= 1'b1;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (words_done + COUNT_WIDTH'(1) == count) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            awaddr  <= awaddr + C_M_AXI_ADDR_WIDTH'(4);
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= S_WRITE;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_fill_master.sv
// Bench for axi_fill_master: table of fill commands against a delay-programmable slave with a write scoreboard.
module tb_axi_fill_master;
    localparam int AW = 19;
    localparam int CW = 17;

    logic          Clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [31:0]   fill_data;
    logic          busy, done, error;
    logic [CW-1:0] words_done;

    axi_fill_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) m ();

    axi_fill_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(32),
        .COUNT_WIDTH(CW)
    ) dut (
        .Clk(Clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .fill_data(fill_data), .busy(busy), .done(done),
        .error(error), .words_done(words_done), .m_axi(m)
    );

    always #5 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;

    typedef struct { logic [AW-1:0] addr; logic [31:0] data; } beat_t;
    beat_t exp_q[$];

    typedef struct {
        logic [AW-1:0] base; logic [CW-1:0] cnt; logic [31:0] data;
        int awd; int wd; int errb;
        logic [CW-1:0] exp_wd; logic exp_err; int exp_lat;
    } vec_t;
    vec_t vecs[8];

    int aw_delay = 0, w_delay = 0, err_beat = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: all decisions at negedge; a pend flag means the handshake fires at the next posedge.
    initial begin
        int aw_wait, w_wait, beat_idx;
        logic got_aw, got_w, aw_pend, w_pend, b_pend, aw_hold, w_hold;
        logic [AW-1:0] aw_cap, hold_addr;
        logic [31:0] w_cap, hold_data;
        logic [3:0] strb_cap;
        logic [2:0] prot_cap;
        aw_wait = 0; w_wait = 0; beat_idx = 0;
        got_aw = 0; got_w = 0; aw_pend = 0; w_pend = 0; b_pend = 0; aw_hold = 0; w_hold = 0;
        aw_cap = '0; hold_addr = '0; w_cap = '0; hold_data = '0; strb_cap = '0; prot_cap = '0;
        m.M_AXI_AWREADY = 0; m.M_AXI_WREADY = 0; m.M_AXI_BVALID = 0; m.M_AXI_BRESP = 2'b00;
        forever begin
            @(negedge Clk);
            if (reset) begin
                aw_wait = 0; w_wait = 0; beat_idx = 0;
                got_aw = 0; got_w = 0; aw_pend = 0; w_pend = 0; b_pend = 0; aw_hold = 0; w_hold = 0;
                m.M_AXI_AWREADY = 0; m.M_AXI_WREADY = 0; m.M_AXI_BVALID = 0; m.M_AXI_BRESP = 2'b00;
            end else begin
                if (!busy) beat_idx = 0;
                if (aw_pend) begin
                    check("aw_once_per_beat", got_aw, 0);
                    check("awprot", prot_cap, 3'b000);
                    got_aw = 1;
                end
                if (w_pend) begin
                    check("w_once_per_beat", got_w, 0);
                    check("wstrb", strb_cap, 4'hF);
                    got_w = 1;
                end
                if (b_pend) begin
                    m.M_AXI_BVALID = 0;
                    beat_idx++;
                    got_aw = 0; got_w = 0;
                end
                if (aw_hold) begin
                    check("awvalid_held", m.M_AXI_AWVALID, 1);
                    check("awaddr_stable", m.M_AXI_AWADDR, hold_addr);
                end
                if (w_hold) begin
                    check("wvalid_held", m.M_AXI_WVALID, 1);
                    check("wdata_stable", m.M_AXI_WDATA, hold_data);
                end
                if (got_aw && got_w && !m.M_AXI_BVALID) begin
                    if (exp_q.size() == 0) begin
                        check("extra_write", 1, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("write_addr", aw_cap, e.addr);
                        check("write_data", w_cap, e.data);
                    end
                    m.M_AXI_BVALID = 1;
                    m.M_AXI_BRESP  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                end
                b_pend = m.M_AXI_BVALID && m.M_AXI_BREADY;
                if (m.M_AXI_AWVALID) begin
                    if (aw_wait >= aw_delay) m.M_AXI_AWREADY = 1;
                    else begin m.M_AXI_AWREADY = 0; aw_wait++; end
                end else m.M_AXI_AWREADY = 0;
                if (m.M_AXI_WVALID) begin
                    if (w_wait >= w_delay) m.M_AXI_WREADY = 1;
                    else begin m.M_AXI_WREADY = 0; w_wait++; end
                end else m.M_AXI_WREADY = 0;
                aw_hold = m.M_AXI_AWVALID && !m.M_AXI_AWREADY;
                w_hold  = m.M_AXI_WVALID && !m.M_AXI_WREADY;
                hold_addr = m.M_AXI_AWADDR;
                hold_data = m.M_AXI_WDATA;
                aw_pend = m.M_AXI_AWVALID && m.M_AXI_AWREADY;
                w_pend  = m.M_AXI_WVALID && m.M_AXI_WREADY;
                if (aw_pend) begin aw_cap = m.M_AXI_AWADDR; prot_cap = m.M_AXI_AWPROT; aw_wait = 0; end
                if (w_pend)  begin w_cap = m.M_AXI_WDATA; strb_cap = m.M_AXI_WSTRB; w_wait = 0; end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the idle cycle after done.
    task automatic do_cmd(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic [31:0] d,
                          input int awd, input int wd, input int errb,
                          input logic [CW-1:0] exp_wd, input logic exp_err, input int exp_lat,
                          input int noise);
        int cyc, nw;
        logic fin;
        aw_delay = awd; w_delay = wd; err_beat = errb;
        nw = (errb >= 0 && errb < int'(n)) ? errb + 1 : int'(n);
        for (int i = 0; i < nw; i++) begin
            beat_t e;
            e.addr = (b & ~AW'(3)) + AW'(4 * i);
            e.data = d;
            exp_q.push_back(e);
        end
        base_addr = b; word_count = n; fill_data = d; start = 1;
        cyc = 0; fin = 0;
        while (!fin && cyc < 400) begin
            @(negedge Clk);
            cyc++;
            if (cyc <= noise) begin
                start = 1; base_addr = 19'h00900; word_count = 1; fill_data = 32'h1111_1111;
            end else start = 0;
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (done) fin = 1;
        end
        start = 0;
        check("done_seen", fin, 1);
        if (exp_lat != 0) check("done_latency", cyc, exp_lat);
        check("words_done", words_done, exp_wd);
        check("error", error, exp_err);
        check("all_writes_seen", exp_q.size(), 0);
        exp_q.delete();
        @(negedge Clk);
        check("done_one_cycle", done, 0);
        check("busy_cleared", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          base      cnt  data          awd wd errb exp_wd err lat
        vecs[0] = '{19'h00100, 4, 32'hDEADBEEF, 0, 0, -1, 4, 0, 9};
        vecs[1] = '{19'h00200, 2, 32'hA5A5_0001, 3, 0, -1, 2, 0, 0};
        vecs[2] = '{19'h00300, 2, 32'h5A5A_0002, 0, 3, -1, 2, 0, 0};
        vecs[3] = '{19'h00400, 8, 32'hCAFE_0003, 0, 0,  1, 2, 1, 5};
        vecs[4] = '{19'h00500, 0, 32'h0BAD_0004, 0, 0, -1, 0, 0, 1};
        vecs[5] = '{19'h7FFF8, 3, 32'h1234_5678, 0, 0, -1, 3, 0, 7};
        vecs[6] = '{19'h00103, 1, 32'h0000_FFFF, 2, 1, -1, 1, 0, 0};
        vecs[7] = '{19'h00600, 3, 32'h8765_4321, 1, 2, -1, 3, 0, 0};

        reset = 1; start = 0; base_addr = '0; word_count = '0; fill_data = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words_done", words_done, 0);
        check("rst_awvalid", m.M_AXI_AWVALID, 0);
        check("rst_wvalid", m.M_AXI_WVALID, 0);
        check("rst_bready", m.M_AXI_BREADY, 0);
        check("rst_awaddr", m.M_AXI_AWADDR, 0);
        check("rst_wdata", m.M_AXI_WDATA, 0);
        reset = 0;
        @(negedge Clk);

        // Consecutive vectors start in the idle cycle right after done: back-to-back acceptance.
        for (int v = 0; v < 8; v++)
            do_cmd(vecs[v].base, vecs[v].cnt, vecs[v].data, vecs[v].awd, vecs[v].wd, vecs[v].errb,
                   vecs[v].exp_wd, vecs[v].exp_err, vecs[v].exp_lat, 0);

        // Start pulses while busy must not disturb the latched command.
        do_cmd(19'h00700, 3, 32'h7777_0007, 2, 0, -1, 3, 0, 0, 3);

        // Reset while a write address is outstanding.
        aw_delay = 5; w_delay = 0; err_beat = -1;
        base_addr = 19'h00800; word_count = 4; fill_data = 32'hFEED_0008; start = 1;
        @(negedge Clk);
        start = 0;
        check("pre_reset_awvalid", m.M_AXI_AWVALID, 1);
        @(negedge Clk);
        reset = 1;
        @(negedge Clk);
        check("mid_rst_awvalid", m.M_AXI_AWVALID, 0);
        check("mid_rst_wvalid", m.M_AXI_WVALID, 0);
        check("mid_rst_bready", m.M_AXI_BREADY, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_words_done", words_done, 0);
        @(negedge Clk);
        reset = 0;
        exp_q.delete();
        @(negedge Clk);
        do_cmd(19'h00A00, 2, 32'h0A0A_0A0A, 0, 0, -1, 2, 0, 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
